// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch controller and program memory.
//   fetch_state_t     : fetch sequencer state encoding (IDLE, RUN, HALT)
//   ADDR_WIDTH_DEF    : default program memory address / PC width
//   INSTR_WIDTH_DEF   : default instruction word width
package cpu_pkg;

  localparam int ADDR_WIDTH_DEF  = 4;
  localparam int INSTR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for an asynchronous-read program memory.
// Owns the PC, presents it as the memory address, and captures the returned
// word into a one-entry output buffer with a valid/ready handshake to decode.
// Ports:
//   clk, n_reset                : clock (rising edge), async active-low reset
//   start, halt                 : begin fetching / stop fetching
//   branch_en, branch_target    : redirect PC, flush the buffered instruction
//   mem_addr, mem_instr         : program memory address out / read data in
//   instr, instr_pc             : buffered instruction and its fetch address
//   instr_valid, instr_ready    : handshake towards decode
//   halted                      : high while in HALT
import cpu_pkg::*;

module fetch_controller #(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_instr,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  load;

  // A fetch happens only when running, not being redirected or stopped,
  // and the buffer is empty or being drained this cycle.
  assign load     = (state == RUN) && !halt && !branch_en &&
                    (!instr_valid || instr_ready);
  assign mem_addr = pc;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      halted      <= 1'b0;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      // State sequencing; halt dominates start, branch never moves state.
      case (state)
        RUN: begin
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
        end
      endcase

      // Buffer and PC; a branch discards the buffer even if it was accepted.
      if (branch_en) begin
        pc          <= branch_target;
        instr_valid <= 1'b0;
      end else if (load) begin
        instr       <= mem_instr;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + ADDR_WIDTH'(1);
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start, halt, branch_en, instr_ready;
  logic [3:0]  branch_target;
  logic [3:0]  mem_addr;
  logic [11:0] mem_instr;
  logic [11:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  logic [11:0] mem [16];
  assign mem_instr = mem[mem_addr];

  fetch_controller #(.ADDR_WIDTH(4), .INSTR_WIDTH(12)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .halt(halt),
    .branch_en(branch_en), .branch_target(branch_target),
    .mem_addr(mem_addr), .mem_instr(mem_instr), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       st, hl, br;
    logic [3:0] tg;
    logic       rd;
    logic       vld;
    logic [3:0] ipc;
    logic [11:0] ins;
    logic       hlt;
    logic [3:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic st, hl, br, input logic [3:0] tg,
                              input logic rd, vld, input logic [3:0] ipc,
                              input logic [11:0] ins, input logic hlt,
                              input logic [3:0] addr);
    vec_t v;
    v.st = st; v.hl = hl; v.br = br; v.tg = tg; v.rd = rd;
    v.vld = vld; v.ipc = ipc; v.ins = ins; v.hlt = hlt; v.addr = addr;
    return v;
  endfunction

  task automatic drive(input logic st, hl, br, input logic [3:0] tg, input logic rd);
    start = st; halt = hl; branch_en = br; branch_target = tg; instr_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[19];
  int   exp_pc_q[$];
  int   cyc;
  int   stall_cnt;
  int   epc;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h100 + 12'(i);

    //      st hl br tg    rd  vld ipc   ins      hlt addr
    vt[0]  = mk(1, 0, 0, 4'h0, 0, 0, 4'h0, 12'h000, 0, 4'h0); // start -> RUN
    vt[1]  = mk(0, 0, 0, 4'h0, 1, 1, 4'h0, 12'h100, 0, 4'h1); // first load
    vt[2]  = mk(0, 0, 0, 4'h0, 1, 1, 4'h1, 12'h101, 0, 4'h2);
    vt[3]  = mk(0, 0, 0, 4'h0, 1, 1, 4'h2, 12'h102, 0, 4'h3);
    vt[4]  = mk(0, 0, 0, 4'h0, 1, 1, 4'h3, 12'h103, 0, 4'h4);
    vt[5]  = mk(0, 0, 1, 4'hA, 0, 0, 4'h3, 12'h103, 0, 4'hA); // branch flushes pc3
    vt[6]  = mk(0, 0, 0, 4'h0, 1, 1, 4'hA, 12'h10A, 0, 4'hB);
    vt[7]  = mk(0, 0, 0, 4'h0, 0, 1, 4'hA, 12'h10A, 0, 4'hB); // stall
    vt[8]  = mk(0, 0, 0, 4'h0, 0, 1, 4'hA, 12'h10A, 0, 4'hB);
    vt[9]  = mk(0, 0, 0, 4'h0, 1, 1, 4'hB, 12'h10B, 0, 4'hC);
    vt[10] = mk(0, 1, 0, 4'h0, 0, 1, 4'hB, 12'h10B, 1, 4'hC); // halt, no load
    vt[11] = mk(0, 0, 0, 4'h0, 0, 1, 4'hB, 12'h10B, 1, 4'hC);
    vt[12] = mk(0, 0, 0, 4'h0, 1, 0, 4'hB, 12'h10B, 1, 4'hC); // accepted, drops
    vt[13] = mk(1, 1, 0, 4'h0, 1, 0, 4'hB, 12'h10B, 1, 4'hC); // start+halt: HALT
    vt[14] = mk(1, 0, 0, 4'h0, 1, 0, 4'hB, 12'h10B, 0, 4'hC); // resume
    vt[15] = mk(0, 0, 0, 4'h0, 1, 1, 4'hC, 12'h10C, 0, 4'hD); // frozen PC used
    vt[16] = mk(0, 1, 1, 4'h2, 1, 0, 4'hC, 12'h10C, 1, 4'h2); // branch+halt
    vt[17] = mk(1, 0, 0, 4'h0, 0, 0, 4'hC, 12'h10C, 0, 4'h2);
    vt[18] = mk(0, 0, 0, 4'h0, 1, 1, 4'h2, 12'h102, 0, 4'h3);

    // Reset state
    n_reset = 1'b0;
    drive(0, 0, 0, 4'h0, 0);
    #12;
    chk("reset_valid",  int'(instr_valid), 0);
    chk("reset_addr",   int'(mem_addr),    0);
    chk("reset_instr",  int'(instr),       0);
    chk("reset_pc",     int'(instr_pc),    0);
    chk("reset_halted", int'(halted),      0);
    @(negedge clk);
    n_reset = 1'b1;

    // Idle without start must not fetch
    drive(0, 0, 0, 4'h0, 1);
    tick();
    chk("idle_valid", int'(instr_valid), 0);
    chk("idle_addr",  int'(mem_addr),    0);

    // Table-driven sequence
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].st, vt[i].hl, vt[i].br, vt[i].tg, vt[i].rd);
      tick();
      chk($sformatf("v%0d_valid", i), int'(instr_valid), int'(vt[i].vld));
      chk($sformatf("v%0d_halted", i), int'(halted), int'(vt[i].hlt));
      chk($sformatf("v%0d_addr", i), int'(mem_addr), int'(vt[i].addr));
      if (vt[i].vld) begin
        chk($sformatf("v%0d_ipc", i), int'(instr_pc), int'(vt[i].ipc));
        chk($sformatf("v%0d_instr", i), int'(instr), int'(vt[i].ins));
      end
    end

    // Streaming run with wrap and a 3-cycle stall at pc 5, scoreboarded
    n_reset = 1'b0;
    #2;
    @(negedge clk);
    n_reset = 1'b1;
    drive(1, 0, 0, 4'h0, 0);
    tick();
    for (int i = 0; i < 16; i++) exp_pc_q.push_back(i);
    for (int i = 0; i < 6; i++) exp_pc_q.push_back(i);
    cyc = 0;
    stall_cnt = 0;
    while (exp_pc_q.size() > 0 && cyc < 60) begin
      cyc++;
      if (instr_valid && instr_pc == 4'h5 && exp_pc_q.size() == 17 && stall_cnt < 3) begin
        stall_cnt++;
        drive(0, 0, 0, 4'h0, 0);
        chk("stall_addr",  int'(mem_addr), 6);
        chk("stall_instr", int'(instr),    12'h105);
        chk("stall_pc",    int'(instr_pc), 5);
      end else begin
        drive(0, 0, 0, 4'h0, 1);
        if (instr_valid) begin
          epc = exp_pc_q.pop_front();
          chk("stream_pc",    int'(instr_pc), epc);
          chk("stream_instr", int'(instr),    int'(12'h100 + 12'(epc)));
        end
      end
      if (exp_pc_q.size() > 0) tick();
    end
    chk("stream_done", exp_pc_q.size(), 0);
    chk("stream_cycles", cyc, 26);

    // Async reset in the middle of a stall
    drive(0, 0, 0, 4'h0, 0);
    tick();
    chk("prereset_valid", int'(instr_valid), 1);
    #3;
    n_reset = 1'b0;
    #1;
    chk("areset_valid", int'(instr_valid), 0);
    chk("areset_addr",  int'(mem_addr),    0);
    chk("areset_instr", int'(instr),       0);
    chk("areset_pc",    int'(instr_pc),    0);
    @(negedge clk);
    n_reset = 1'b1;
    drive(0, 0, 0, 4'h0, 1);
    tick();
    chk("postreset_idle_valid", int'(instr_valid), 0);
    chk("postreset_idle_addr",  int'(mem_addr),    0);
    drive(1, 0, 0, 4'h0, 1);
    tick();
    drive(0, 0, 0, 4'h0, 1);
    tick();
    chk("postreset_valid", int'(instr_valid), 1);
    chk("postreset_instr", int'(instr),       12'h100);
    chk("postreset_addr",  int'(mem_addr),    1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer for the asynchronous-read program memory. It owns the program counter (PC) and drives the memory address. It registers the returned instruction into a one-entry output buffer with a valid/ready handshake to decode. It also handles start, halt and branch redirects. It sits between program memory and the decode/execute stage.

## Interface
- ADDR_WIDTH, 4, program memory address width; PC width
- INSTR_WIDTH, 12, instruction word width
- clk  in  1  system clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin fetching at current PC
- halt  in  1  stop fetching new instructions
- branch_en  in  1  redirect PC to branch_target, flush buffered instruction
- branch_target  in  ADDR_WIDTH  redirect address
- mem_addr  out  ADDR_WIDTH  address to program memory (= PC register)
- mem_instr  in  INSTR_WIDTH  combinational read data from program memory
- instr  out  INSTR_WIDTH  buffered instruction to decode
- instr_pc  out  ADDR_WIDTH  address that instr was fetched from
- instr_valid  out  1  instr holds a valid instruction
- instr_ready  in  1  decode accepts instr this cycle
- halted  out  1  high in HALT state

## Operation
- States: IDLE, RUN, HALT.
- Reset values: state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
- Load condition: `load = (state==RUN) && !halt && !branch_en && (!instr_valid || instr_ready)`.
- On load:
  - instr<=mem_instr and instr_pc<=PC.
  - instr_valid<=1.
  - PC<=PC+1, modulo 2^ADDR_WIDTH, so 2^ADDR_WIDTH-1 wraps to 0 silently.
- Accept without load: if instr_valid && instr_ready && !load, then instr_valid<=0.
- Stall: if instr_valid && !instr_ready, then instr, instr_pc, instr_valid and PC all hold.
- Branch (any state, highest priority):
  - PC<=branch_target and instr_valid<=0. The buffered instruction is discarded even if instr_ready was high that cycle.
  - State is unchanged.
- Halt:
  - In RUN with halt=1 and branch_en=0, state<=HALT and no load occurs.
  - A valid buffered instruction stays valid until accepted, then drops.
  - If branch_en=1 in the same cycle, the branch applies and state<=HALT.
- Start:
  - IDLE/HALT with start=1, state<=RUN. Fetching begins at the current PC on the following edge.
  - start in RUN is ignored.
  - start and halt together: halt wins, and state goes to or stays HALT.
- halted = (state==HALT), registered with the state.
- Reset mid-operation clears everything immediately; no partial fetch survives.

## Timing
- mem_addr is driven directly from the PC register, with no combinational path from inputs.
- Start asserted before edge k gives state=RUN after k. Edge k+1 loads mem[PC] and sets instr_valid=1.
- With instr_ready held high, throughput is one instruction per cycle. Consecutive instr_pc values increment by 1.
- Branch sampled at edge b:
  - After b: PC=target and instr_valid=0.
  - Edge b+1 loads mem[target].
  - Cost: one-cycle bubble.
- Halt sampled at edge h: no load at h. Any instruction loaded at h-1 remains presented.
- All outputs are registered, apart from mem_addr, which is the PC register itself.

## Structure
- Shared package `cpu_pkg`:
  - fetch_state_t enum {IDLE, RUN, HALT}.
  - Default ADDR_WIDTH/INSTR_WIDTH constants shared with program memory.
- No sub-module. The CPU top instantiates fetch_controller and program memory side by side, connecting mem_addr/mem_instr.

## Test plan
- Reset, then start, ready=1, memory mem[i]=0x100+i → instr 0x100,0x101,0x102… on consecutive cycles, instr_pc 0,1,2…
- Continuous run with 2^ADDR_WIDTH=16 words → after instr_pc=15 the next instr_pc=0 (wrap), no gap.
- ready=0 for 3 cycles while instr_pc=5 → instr, instr_pc, mem_addr=6 all stable; on ready=1 the next instr_pc=6.
- branch_en with target=0xA while instr_pc=3 valid and ready=0 → instr_valid=0 next cycle (instr 3 discarded), then instr_pc=0xA, one bubble.
- halt while running → no new loads, halted=1, PC frozen; start → resumes at the frozen PC; start+halt together → stays HALT.
- n_reset pulsed low mid-stall (async, between edges) → outputs zero immediately, state IDLE, PC=0, no fetch until start.
